// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared pwm definitions: gate-drive FSM state encoding and default timing constants
package pwm_pkg;

    // Gate-drive FSM states. Only HIGH_ON and LOW_ON drive a gate.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAD    = 3'd1,
        ST_HIGH_ON = 3'd2,
        ST_LOW_ON  = 3'd3,
        ST_FAULT   = 3'd4
    } dt_state_t;

    // 10 cycles at 5 MHz gives 2 us of dead time.
    localparam int DEAD_CYCLES_DEFAULT = 10;
    localparam int CNT_WIDTH_DEFAULT   = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
//
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized output, two clk edges after d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dead_time_gen.sv
// rtl/dead_time_gen.sv - half-bridge gate driver with dead-time insertion, enable and latched fault
//
// Ports:
//   ClkOsc        - clock, rising edge
//   Rst           - asynchronous active-low reset
//   Pwm_In        - asynchronous PWM from the modulator
//   Enable        - 1 runs the bridge, 0 forces IDLE (both gates off)
//   Fault         - asynchronous active-high fault
//   Fault_Clr     - single-cycle request to leave FAULT
//   Out_High      - high-side gate drive (registered)
//   Out_Low       - low-side gate drive (registered)
//   Dead_Active   - high while in DEAD (registered)
//   Fault_Latched - high while in FAULT (registered)
module dead_time_gen
    import pwm_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEFAULT
) (
    input  logic ClkOsc,
    input  logic Rst,
    input  logic Pwm_In,
    input  logic Enable,
    input  logic Fault,
    input  logic Fault_Clr,
    output logic Out_High,
    output logic Out_Low,
    output logic Dead_Active,
    output logic Fault_Latched
);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 2 ** CNT_WIDTH) begin : g_bad_dead_cycles
        $error("dead_time_gen: DEAD_CYCLES must be in 1..2**CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DEAD_CYCLES - 1);

    logic pwm_s;
    logic fault_s;

    sync_2ff u_sync_pwm (
        .clk   (ClkOsc),
        .rst_n (Rst),
        .d     (Pwm_In),
        .q     (pwm_s)
    );

    sync_2ff u_sync_fault (
        .clk   (ClkOsc),
        .rst_n (Rst),
        .d     (Fault),
        .q     (fault_s)
    );

    dt_state_t             state;
    dt_state_t             next_state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  high_d;
    logic                  low_d;
    logic                  dead_d;
    logic                  fault_d;

    // State register. Outputs are registered from the next-state decode so they
    // change on the same edge as the state and are cleared asynchronously by reset.
    always_ff @(posedge ClkOsc or negedge Rst) begin
        if (!Rst) begin
            state         <= ST_IDLE;
            Out_High      <= 1'b0;
            Out_Low       <= 1'b0;
            Dead_Active   <= 1'b0;
            Fault_Latched <= 1'b0;
        end else begin
            state         <= next_state;
            Out_High      <= high_d;
            Out_Low       <= low_d;
            Dead_Active   <= dead_d;
            Fault_Latched <= fault_d;
        end
    end

    // Next-state logic: fault beats disable beats normal switching.
    always_comb begin
        next_state = state;
        if (state == ST_FAULT) begin
            if (Fault_Clr && !fault_s) begin
                next_state = ST_IDLE;
            end
        end else if (fault_s) begin
            next_state = ST_FAULT;
        end else if (!Enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    next_state = ST_DEAD;
                ST_DEAD:    if (cnt == '0) next_state = pwm_s ? ST_HIGH_ON : ST_LOW_ON;
                ST_HIGH_ON: if (!pwm_s) next_state = ST_DEAD;
                ST_LOW_ON:  if (pwm_s) next_state = ST_DEAD;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode. Only one of the two drive states can be selected, so the
    // gates can never both be on.
    always_comb begin
        high_d  = (next_state == ST_HIGH_ON);
        low_d   = (next_state == ST_LOW_ON);
        dead_d  = (next_state == ST_DEAD);
        fault_d = (next_state == ST_FAULT);
    end

    // Dead-time counter: loaded once on DEAD entry and never reloaded while in
    // DEAD, so pwm_s glitches inside the interval are absorbed. DEAD lasts
    // CNT_LOAD decrements plus the exit edge, i.e. DEAD_CYCLES cycles.
    always_ff @(posedge ClkOsc or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (next_state == ST_DEAD && state != ST_DEAD) begin
            cnt <= CNT_LOAD;
        end else if (state == ST_DEAD && cnt != '0) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: tb/tb_dead_time_gen.sv
// tb/tb_dead_time_gen.sv - self-checking bench for dead_time_gen (DEAD_CYCLES=10 and DEAD_CYCLES=1)
module tb_dead_time_gen;

    logic ClkOsc    = 1'b0;
    logic Rst       = 1'b0;
    logic Pwm_In    = 1'b0;
    logic Enable    = 1'b0;
    logic Fault     = 1'b0;
    logic Fault_Clr = 1'b0;

    logic oh [2];
    logic ol [2];
    logic da [2];
    logic fl [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 ClkOsc = ~ClkOsc;

    dead_time_gen #(.DEAD_CYCLES(10), .CNT_WIDTH(8)) u_dut10 (
        .ClkOsc        (ClkOsc),
        .Rst           (Rst),
        .Pwm_In        (Pwm_In),
        .Enable        (Enable),
        .Fault         (Fault),
        .Fault_Clr     (Fault_Clr),
        .Out_High      (oh[0]),
        .Out_Low       (ol[0]),
        .Dead_Active   (da[0]),
        .Fault_Latched (fl[0])
    );

    dead_time_gen #(.DEAD_CYCLES(1), .CNT_WIDTH(4)) u_dut1 (
        .ClkOsc        (ClkOsc),
        .Rst           (Rst),
        .Pwm_In        (Pwm_In),
        .Enable        (Enable),
        .Fault         (Fault),
        .Fault_Clr     (Fault_Clr),
        .Out_High      (oh[1]),
        .Out_Low       (ol[1]),
        .Dead_Active   (da[1]),
        .Fault_Latched (fl[1])
    );

    // Reference model: which gate is driven (0 none, 1 high, 2 low), how many
    // dead cycles remain, and whether the bridge is parked or faulted.
    int dcyc      [2] = '{10, 1};
    int drive     [2];
    int dead_left [2];
    bit faulted   [2];
    bit parked    [2];
    // Inputs as seen at the previous two clock edges (synchronizer delay).
    bit pq1, pq2, fq1, fq2;

    task automatic check(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            drive[i]     = 0;
            dead_left[i] = 0;
            faulted[i]   = 1'b0;
            parked[i]    = 1'b1;
        end
        pq1 = 1'b0; pq2 = 1'b0; fq1 = 1'b0; fq2 = 1'b0;
    endtask

    task automatic model_step(int i, bit en, bit fclr, bit ps, bit fs);
        if (faulted[i]) begin
            if (fclr && !fs) begin
                faulted[i] = 1'b0;
                parked[i]  = 1'b1;
            end
        end else if (fs) begin
            faulted[i]   = 1'b1;
            drive[i]     = 0;
            dead_left[i] = 0;
            parked[i]    = 1'b0;
        end else if (!en) begin
            parked[i]    = 1'b1;
            drive[i]     = 0;
            dead_left[i] = 0;
        end else if (parked[i]) begin
            parked[i]    = 1'b0;
            dead_left[i] = dcyc[i];
        end else if (dead_left[i] > 0) begin
            if (dead_left[i] == 1) begin
                dead_left[i] = 0;
                drive[i]     = ps ? 1 : 2;
            end else begin
                dead_left[i]--;
            end
        end else if ((drive[i] == 1 && !ps) || (drive[i] == 2 && ps)) begin
            drive[i]     = 0;
            dead_left[i] = dcyc[i];
        end
    endtask

    task automatic check_all(string ph);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s d%0d Out_High", ph, dcyc[i]), oh[i], logic'(drive[i] == 1));
            check($sformatf("%s d%0d Out_Low", ph, dcyc[i]), ol[i], logic'(drive[i] == 2));
            check($sformatf("%s d%0d Dead_Active", ph, dcyc[i]), da[i], logic'(dead_left[i] > 0));
            check($sformatf("%s d%0d Fault_Latched", ph, dcyc[i]), fl[i], logic'(faulted[i]));
            check($sformatf("%s d%0d both_on", ph, dcyc[i]), oh[i] & ol[i], 1'b0);
        end
    endtask

    task automatic tick(string ph);
        bit ps, fs;
        @(posedge ClkOsc);
        if (!Rst) begin
            model_reset();
        end else begin
            ps = pq2; fs = fq2;
            pq2 = pq1; pq1 = Pwm_In;
            fq2 = fq1; fq1 = Fault;
            for (int i = 0; i < 2; i++) model_step(i, Enable, Fault_Clr, ps, fs);
        end
        #1;
        check_all(ph);
    endtask

    task automatic ticks(int n, string ph);
        for (int k = 0; k < n; k++) tick(ph);
    endtask

    initial begin
        model_reset();

        // Reset state
        ticks(3, "reset");
        Rst = 1'b1;
        Enable = 1'b1;

        // Normal switching, 100/100 square wave
        for (int p = 0; p < 2; p++) begin
            Pwm_In = 1'b1; ticks(100, "square_hi");
            Pwm_In = 1'b0; ticks(100, "square_lo");
        end

        // Short high pulse during LOW_ON is absorbed
        ticks(10, "pre_glitch");
        Pwm_In = 1'b1; ticks(4, "glitch");
        Pwm_In = 1'b0; ticks(30, "post_glitch");

        // Fault during HIGH_ON, clear ignored while fault persists
        Pwm_In = 1'b1; ticks(30, "high_on");
        Fault = 1'b1; ticks(5, "fault");
        Fault_Clr = 1'b1; tick("clr_ignored");
        Fault_Clr = 1'b0; ticks(3, "fault_hold");
        Fault = 1'b0; ticks(4, "fault_gone");
        Fault_Clr = 1'b1; tick("fault_clr");
        Fault_Clr = 1'b0; ticks(25, "after_clr");

        // Disable in the middle of DEAD, then re-enable
        Pwm_In = 1'b0; ticks(6, "into_dead");
        Enable = 1'b0; ticks(3, "disabled");
        Enable = 1'b1; ticks(20, "reenabled");

        // Asynchronous reset between edges while Out_Low is on
        ticks(5, "low_on");
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        ticks(2, "in_reset");
        Rst = 1'b1;
        ticks(20, "after_reset");

        // Toggle every 2 cycles (minimum dead time on the DEAD_CYCLES=1 part)
        for (int k = 0; k < 20; k++) begin
            Pwm_In = ~Pwm_In;
            ticks(2, "fast_toggle");
        end

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(11) == 0) Pwm_In = ~Pwm_In;
            if (Enable) begin
                if ($urandom_range(199) == 0) Enable = 1'b0;
            end else if ($urandom_range(9) == 0) begin
                Enable = 1'b1;
            end
            if (Fault) begin
                if ($urandom_range(14) == 0) Fault = 1'b0;
            end else if ($urandom_range(399) == 0) begin
                Fault = 1'b1;
            end
            Fault_Clr = ($urandom_range(29) == 0);
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
